// File: rtl/riscv_lsu_pkg.sv
// Shared LSU definitions: access-size codes, FSM states, error codes and
// the bus-lane helpers used by the controller.
package riscv_lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RSP,
        S_DONE,
        S_ERR
    } lsu_state_e;

    typedef enum logic [1:0] {
        ERR_MISALIGN = 2'd0,
        ERR_SIZE     = 2'd1,
        ERR_TIMEOUT  = 2'd2
    } lsu_err_e;

    function automatic logic size_legal(input logic [2:0] size);
        return size inside {LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU};
    endfunction

    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] off);
        case (size)
            LDST_H, LDST_HU: return off[0];
            LDST_W:          return off != 2'b00;
            default:         return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] off);
        case (size)
            LDST_B, LDST_BU: return 4'b0001 << off;
            LDST_H, LDST_HU: return 4'b0011 << off;
            default:         return 4'b1111;
        endcase
    endfunction

    // Replicate the store operand across every lane it could land in.
    function automatic logic [31:0] store_data(input logic [2:0] size, input logic [31:0] wd);
        case (size)
            LDST_B, LDST_BU: return {4{wd[7:0]}};
            LDST_H, LDST_HU: return {2{wd[15:0]}};
            default:         return wd;
        endcase
    endfunction

endpackage

// File: rtl/riscv_lsu_rd_align.sv
// Load-data alignment: shifts the addressed lane down and sign/zero extends
// it according to the access size.
module riscv_lsu_rd_align
    import riscv_lsu_pkg::*;
(
    input  logic [31:0] mem_rd,
    input  logic [1:0]  addr,
    input  logic [2:0]  size,
    output logic [31:0] data
);

    logic [31:0] shifted;

    always_comb begin
        shifted = mem_rd >> {addr, 3'b000};
        case (size)
            LDST_B:  data = {{24{shifted[7]}}, shifted[7:0]};
            LDST_BU: data = {24'h000000, shifted[7:0]};
            LDST_H:  data = {{16{shifted[15]}}, shifted[15:0]};
            LDST_HU: data = {16'h0000, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load-store unit controller: runs the req/gnt/rvalid data-bus handshake,
// stalls the core until completion and reports alignment/size/timeout errors.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_err_o,
    output logic [1:0]  core_err_code_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rd_i
);

    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       size_q;
    logic [1:0]       off_q;
    logic [31:0]      rd_ext;
    logic             timeout_hit;

    riscv_lsu_rd_align u_rd_align (
        .mem_rd (mem_rd_i),
        .addr   (off_q),
        .size   (size_q),
        .data   (rd_ext)
    );

    // The counter holds the number of waiting cycles already spent, so the
    // abort fires on the TIMEOUT_CYCLES-th cycle without grant/response.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

    assign core_stall_o = (state == S_REQ) || (state == S_RSP) ||
                          ((state == S_IDLE) && core_req_i);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state           <= S_IDLE;
            cnt             <= '0;
            size_q          <= '0;
            off_q           <= '0;
            core_rd_o       <= '0;
            core_err_o      <= 1'b0;
            core_err_code_o <= '0;
            mem_req_o       <= 1'b0;
            mem_we_o        <= 1'b0;
            mem_be_o        <= '0;
            mem_addr_o      <= '0;
            mem_wd_o        <= '0;
        end else begin
            core_err_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (core_req_i) begin
                        if (!size_legal(core_size_i)) begin
                            state           <= S_ERR;
                            core_err_o      <= 1'b1;
                            core_err_code_o <= ERR_SIZE;
                        end else if (misaligned(core_size_i, core_addr_i[1:0])) begin
                            state           <= S_ERR;
                            core_err_o      <= 1'b1;
                            core_err_code_o <= ERR_MISALIGN;
                        end else begin
                            state      <= S_REQ;
                            cnt        <= '0;
                            size_q     <= core_size_i;
                            off_q      <= core_addr_i[1:0];
                            mem_req_o  <= 1'b1;
                            mem_we_o   <= core_we_i;
                            mem_be_o   <= byte_en(core_size_i, core_addr_i[1:0]);
                            mem_addr_o <= {core_addr_i[31:2], 2'b00};
                            mem_wd_o   <= store_data(core_size_i, core_wd_i);
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        cnt       <= '0;
                        if (mem_we_o) begin
                            state <= S_DONE;
                        end else if (mem_rvalid_i) begin
                            core_rd_o <= rd_ext;
                            state     <= S_DONE;
                        end else begin
                            state <= S_RSP;
                        end
                    end else if (timeout_hit) begin
                        mem_req_o       <= 1'b0;
                        state           <= S_ERR;
                        core_err_o      <= 1'b1;
                        core_err_code_o <= ERR_TIMEOUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RSP: begin
                    if (mem_rvalid_i) begin
                        core_rd_o <= rd_ext;
                        state     <= S_DONE;
                    end else if (timeout_hit) begin
                        state           <= S_ERR;
                        core_err_o      <= 1'b1;
                        core_err_code_o <= ERR_TIMEOUT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_lsu.sv
// Bench for riscv_lsu: per-transaction reference timeline derived from the
// access rules, directed literal cases and randomized traffic.
module tb_riscv_lsu;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req, core_we;
    logic [2:0]  core_size;
    logic [31:0] core_addr, core_wd;
    logic [31:0] core_rd;
    logic        core_stall, core_err;
    logic [1:0]  core_err_code;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wd;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rd;

    always #5 clk = ~clk;

    riscv_lsu #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .core_req_i      (core_req),
        .core_we_i       (core_we),
        .core_size_i     (core_size),
        .core_addr_i     (core_addr),
        .core_wd_i       (core_wd),
        .core_rd_o       (core_rd),
        .core_stall_o    (core_stall),
        .core_err_o      (core_err),
        .core_err_code_o (core_err_code),
        .mem_req_o       (mem_req),
        .mem_we_o        (mem_we),
        .mem_be_o        (mem_be),
        .mem_addr_o      (mem_addr),
        .mem_wd_o        (mem_wd),
        .mem_gnt_i       (mem_gnt),
        .mem_rvalid_i    (mem_rvalid),
        .mem_rd_i        (mem_rd)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic        chk_on = 1'b0;
    logic        exp_stall, exp_req, exp_err, exp_rd_chk, exp_we;
    logic [1:0]  exp_code;
    logic [31:0] exp_rd, exp_addr, exp_wd;
    logic [3:0]  exp_be;
    logic [31:0] last_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("core_stall", 32'(core_stall), 32'(exp_stall));
            check("mem_req", 32'(mem_req), 32'(exp_req));
            check("core_err", 32'(core_err), 32'(exp_err));
            if (exp_err) check("err_code", 32'(core_err_code), 32'(exp_code));
            if (exp_req) begin
                check("mem_we", 32'(mem_we), 32'(exp_we));
                check("mem_be", 32'(mem_be), 32'(exp_be));
                check("mem_addr", mem_addr, exp_addr);
                if (exp_we) check("mem_wd", mem_wd, exp_wd);
            end
            if (exp_rd_chk) check("core_rd", core_rd, exp_rd);
        end
    end

    function automatic int unsigned acc_bytes(input logic [2:0] size);
        case (size)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [31:0] load_value(input logic [2:0] size, input logic [31:0] addr,
                                               input logic [31:0] word);
        int unsigned n = acc_bytes(size);
        logic [31:0] mask;
        logic [31:0] v;
        v    = word >> (8 * addr[1:0]);
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        v    = v & mask;
        if (n < 4 && size < 3'd4 && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic set_exp(input logic stall, input logic req, input logic err,
                           input logic [1:0] code, input logic rd_chk, input logic [31:0] rd);
        exp_stall  = stall;
        exp_req    = req;
        exp_err    = err;
        exp_code   = code;
        exp_rd_chk = rd_chk;
        exp_rd     = rd;
    endtask

    task automatic wait_cycle(inout int unsigned stalls, inout logic [31:0] rd_seen,
                              inout logic [3:0] be_seen, inout logic [31:0] wd_seen,
                              inout logic [1:0] code_seen);
        #4;
        if (core_stall === 1'b1) stalls++;
        if (mem_req === 1'b1) begin
            be_seen = mem_be;
            wd_seen = mem_wd;
        end
        if (core_err === 1'b1) code_seen = core_err_code;
        if (exp_rd_chk) rd_seen = core_rd;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] word,
                          input int unsigned g, input int unsigned r,
                          output int unsigned stalls, output logic [31:0] rd_seen,
                          output logic [3:0] be_seen, output logic [31:0] wd_seen,
                          output logic [1:0] code_seen);
        int unsigned n     = acc_bytes(size);
        bit          legal = (size != 3'd3) && (size < 3'd6);
        bit          mis   = legal && ((addr % n) != 0);
        bit          granted  = 1'b0;
        bit          finished = 1'b0;
        stalls = 0; rd_seen = '0; be_seen = '0; wd_seen = '0; code_seen = 2'b11;

        core_req = 1'b1; core_we = we; core_size = size; core_addr = addr; core_wd = wd;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        exp_we   = we;
        exp_be   = 4'(((1 << n) - 1) << addr[1:0]);
        exp_addr = addr & ~32'd3;
        exp_wd   = (n == 1) ? {24'h0, wd[7:0]} * 32'h0101_0101 :
                   (n == 2) ? {16'h0, wd[15:0]} * 32'h0001_0001 : wd;
        set_exp(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, '0);
        wait_cycle(stalls, rd_seen, be_seen, wd_seen, code_seen);

        if (!legal || mis) begin
            set_exp(1'b0, 1'b0, 1'b1, legal ? 2'd0 : 2'd1, 1'b0, '0);
            wait_cycle(stalls, rd_seen, be_seen, wd_seen, code_seen);
            core_req = 1'b0;
            set_exp(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, '0);
            return;
        end

        for (int unsigned k = 0; k < TO && !granted; k++) begin
            set_exp(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, '0);
            mem_gnt = (k == g);
            mem_rd  = $urandom;
            if (k == g && !we && r == 0) begin
                mem_rvalid = 1'b1;
                mem_rd     = word;
            end
            wait_cycle(stalls, rd_seen, be_seen, wd_seen, code_seen);
            granted    = (k == g);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
        end

        if (granted && !we && r != 0) begin
            for (int unsigned j = 1; j <= TO && !finished; j++) begin
                set_exp(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, '0);
                mem_rvalid = (j == r);
                mem_rd     = (j == r) ? word : $urandom;
                wait_cycle(stalls, rd_seen, be_seen, wd_seen, code_seen);
                finished   = (j == r);
                mem_rvalid = 1'b0;
            end
        end else begin
            finished = granted;
        end

        if (!finished) begin
            set_exp(1'b0, 1'b0, 1'b1, 2'd2, 1'b0, '0);
            wait_cycle(stalls, rd_seen, be_seen, wd_seen, code_seen);
            // A response arriving after the abort must not reach the core.
            core_req = 1'b0; mem_rvalid = 1'b1; mem_rd = $urandom;
            set_exp(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, last_rd);
            wait_cycle(stalls, rd_seen, be_seen, wd_seen, code_seen);
            mem_rvalid = 1'b0;
            set_exp(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, '0);
            return;
        end

        if (!we) last_rd = load_value(size, addr, word);
        set_exp(1'b0, 1'b0, 1'b0, 2'd0, !we, last_rd);
        wait_cycle(stalls, rd_seen, be_seen, wd_seen, code_seen);
        core_req = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, '0);
    endtask

    int unsigned st;
    logic [31:0] rs, ws;
    logic [3:0]  bs;
    logic [1:0]  cs;

    initial begin
        rst_n = 1'b0; core_req = 1'b0; core_we = 1'b0; core_size = '0;
        core_addr = '0; core_wd = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rd = '0;
        exp_we = 1'b0; exp_be = '0; exp_addr = '0; exp_wd = '0; last_rd = '0;
        set_exp(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        set_exp(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, '0);
        chk_on = 1'b1;
        wait_cycle(st, rs, bs, ws, cs);
        check("reset_mem_be", 32'(mem_be), 32'd0);
        rst_n = 1'b1;
        set_exp(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, '0);
        wait_cycle(st, rs, bs, ws, cs);

        run_op(1'b0, 3'd2, 32'h100, '0, 32'hDEAD_BEEF, 1, 3, st, rs, bs, ws, cs);
        check("lw_stall_cycles", st, 32'd6);
        check("lw_rd", rs, 32'hDEAD_BEEF);
        check("lw_be", 32'(bs), 32'hF);

        run_op(1'b0, 3'd0, 32'h103, '0, 32'h80FF_FFFF, 0, 1, st, rs, bs, ws, cs);
        check("lb_rd", rs, 32'hFFFF_FF80);
        run_op(1'b0, 3'd4, 32'h103, '0, 32'h80FF_FFFF, 0, 1, st, rs, bs, ws, cs);
        check("lbu_rd", rs, 32'h0000_0080);

        run_op(1'b1, 3'd1, 32'h102, 32'h0000_ABCD, '0, 0, 0, st, rs, bs, ws, cs);
        check("sh_be", 32'(bs), 32'hC);
        check("sh_wd", ws, 32'hABCD_ABCD);
        check("sh_stall_cycles", st, 32'd2);

        run_op(1'b0, 3'd2, 32'h101, '0, '0, 0, 0, st, rs, bs, ws, cs);
        check("misalign_code", 32'(cs), 32'd0);
        check("misalign_stall_cycles", st, 32'd1);
        run_op(1'b0, 3'd3, 32'h100, '0, '0, 0, 0, st, rs, bs, ws, cs);
        check("badsize_code", 32'(cs), 32'd1);

        run_op(1'b0, 3'd2, 32'h200, '0, '0, 9, 0, st, rs, bs, ws, cs);
        check("timeout_code", 32'(cs), 32'd2);
        check("timeout_stall_cycles", st, 32'd5);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a = a & ~32'd3;
            run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, $urandom,
                   $urandom_range(0, 5), $urandom_range(0, 5), st, rs, bs, ws, cs);
            repeat ($urandom_range(0, 2)) begin
                mem_rvalid = 1'($urandom_range(0, 1));
                mem_rd     = $urandom;
                wait_cycle(st, rs, bs, ws, cs);
            end
            mem_rvalid = 1'b0;
        end

        // Reset while waiting for a load response; the late response is dropped.
        core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h40;
        exp_we = 1'b0; exp_be = 4'hF; exp_addr = 32'h40;
        set_exp(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, '0);
        wait_cycle(st, rs, bs, ws, cs);
        mem_gnt = 1'b1;
        set_exp(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, '0);
        wait_cycle(st, rs, bs, ws, cs);
        mem_gnt = 1'b0; rst_n = 1'b0;
        set_exp(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, '0);
        wait_cycle(st, rs, bs, ws, cs);
        rst_n = 1'b1; core_req = 1'b0; mem_rvalid = 1'b1; mem_rd = 32'h1234_5678;
        set_exp(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, '0);
        repeat (2) wait_cycle(st, rs, bs, ws, cs);
        mem_rvalid = 1'b0;

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Load-store unit controller between the core pipeline and the data-memory port. It accepts the memory request produced by the instruction decoder, together with the ALU-computed address and the rs2 store data. It then sequences a request/grant/response handshake on the data bus, holds the core stalled until the access completes, and returns aligned, sign/zero-extended load data. Misaligned or illegal-size accesses and bus timeouts are reported to the core instead of being issued or left hanging.

Parameters:
TIMEOUT_CYCLES, 255, max cycles waiting for mem_gnt_i or mem_rvalid_i before abort; 0 disables the timeout.
CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_n_i  in  1  synchronous active-low reset
core_req_i  in  1  decoder mem_req: a memory instruction is in execute
core_we_i  in  1  1 = store, 0 = load
core_size_i  in  3  func3 encoding: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU; 3/6/7 illegal
core_addr_i  in  32  byte address (ALU result)
core_wd_i  in  32  store data (rs2)
core_rd_o  out  32  extended load data; valid in the DONE cycle
core_stall_o  out  1  hold PC/pipeline
core_err_o  out  1  one-cycle pulse: misaligned, illegal size or timeout; no writeback
core_err_code_o  out  2  0 misaligned, 1 illegal size, 2 timeout; valid with core_err_o
mem_req_o  out  1  data-bus request
mem_we_o  out  1  data-bus write enable
mem_be_o  out  4  byte enables
mem_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
mem_wd_o  out  32  lane-replicated store data
mem_gnt_i  in  1  request accepted this cycle
mem_rvalid_i  in  1  read data valid
mem_rd_i  in  32  read data word

Behaviour:
- Reset (rst_n_i=0 at clock edge): state=IDLE, counter=0, all registered outputs 0. core_stall_o=0, mem_req_o=0, core_err_o=0, core_rd_o=0. Any mem_rvalid_i after a mid-operation reset is ignored, because the FSM is in IDLE.
- FSM states: IDLE, REQ, RSP, DONE, ERR.
- IDLE:
  - core_req_i=1 with an illegal size or misaligned address (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): go to ERR. No bus request is issued. core_stall_o=1 this cycle.
  - core_req_i=1 and the access is legal: latch we/size/addr[1:0]/wd and go to REQ. core_stall_o=1.
  - core_req_i=0: stay in IDLE.
- REQ:
  - mem_req_o=1. mem_we_o/mem_be_o/mem_addr_o/mem_wd_o come from the latched values and stay stable until grant.
  - On mem_gnt_i: a store goes to DONE; a load goes to RSP. Clear the counter.
  - mem_gnt_i and mem_rvalid_i in the same cycle for a load: go straight to DONE and capture the data.
- RSP: mem_req_o=0. On mem_rvalid_i, capture the extended data into the core_rd_o register and go to DONE.
- DONE: core_stall_o=0 (the core advances). core_rd_o is held. Return to IDLE next cycle; core_req_i in DONE is ignored because it belongs to the same instruction.
- ERR: core_err_o=1, core_stall_o=0, core_err_code_o set. Return to IDLE next cycle.
- core_stall_o is 1 in REQ and RSP, and combinationally 1 in IDLE when core_req_i=1; it is 0 otherwise.
- Timeout: the counter increments each cycle in REQ or RSP. When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0), go to ERR with code 2 and drop mem_req_o. A late rvalid after the abort is ignored.
- Byte enables:
  - byte access: 4'b0001 << addr[1:0]
  - half access: 4'b0011 << addr[1:0]
  - word access: 4'b1111
- Store data: byte {4{wd[7:0]}}, half {2{wd[15:0]}}, word wd.
- Load extraction: shifted = mem_rd_i >> (8*addr[1:0]). LB sign-extends shifted[7:0]; LBU zero-extends it. LH sign-extends shifted[15:0]; LHU zero-extends it. LW takes the whole word.

Decomposition:
- Add to defines.v: the LSU size codes (LDST_B=3'd0, LDST_H=1, LDST_W=2, LDST_BU=4, LDST_HU=5), the FSM state encodings, and the error codes.
- One combinational sub-module, riscv_lsu_rd_align: inputs mem_rd_i, addr[1:0], size; output the 32-bit extended load data. It is reused by the verification model.

Test Plan:
- LW at 0x100, gnt after 2 cycles, rvalid 3 cycles later with 0xDEADBEEF -> mem_be_o=1111, mem_addr_o=0x100, stall for 6 cycles, DONE cycle core_rd_o=0xDEADBEEF.
- LB at 0x103 with mem_rd_i=0x80FFFFFF -> core_rd_o=0xFFFFFF80; LBU at the same address -> 0x00000080.
- SH at 0x102 with wd=0x0000ABCD, immediate gnt -> mem_be_o=1100, mem_wd_o=0xABCDABCD, mem_we_o=1, no RSP state, stall released the cycle after gnt.
- LW at 0x101 -> no mem_req_o ever, core_err_o one-cycle pulse with code 0; core_size_i=3 -> pulse with code 1.
- TIMEOUT_CYCLES=4, gnt held 0 -> mem_req_o drops after 4 cycles, core_err_o pulse with code 2; a later rvalid causes no change.
- rst_n_i=0 while in RSP, then a later mem_rvalid_i -> FSM stays IDLE, stall=0, core_rd_o=0.
